// File: rtl/pin_check_pkg.sv
// Shared definitions for the PIN check controller: state encoding,
// PIN field widths and default window lengths in clock cycles.
package pin_check_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_CFG = 3'd0,
    ST_IDLE     = 3'd1,
    ST_CHECK    = 3'd2,
    ST_OPEN     = 3'd3,
    ST_FAIL     = 3'd4,
    ST_LOCKOUT  = 3'd5
  } pin_state_e;

  localparam int PIN_A_W = 4;
  localparam int PIN_B_W = 3;

  localparam int DEF_MAX_ATTEMPTS   = 3;
  localparam int DEF_OPEN_CYCLES    = 250_000_000;
  localparam int DEF_FAIL_CYCLES    = 50_000_000;
  localparam int DEF_LOCKOUT_CYCLES = 1_500_000_000;

  // Larger of two window lengths; sizes the shared timer.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pin_cycle_timer.sv
// Loadable down-counter shared by the timed states. Loading N makes
// Expired pulse for one cycle exactly N cycles later (on the N-th cycle
// after the load edge), so a state entered on the load edge lasts N cycles.
module pin_cycle_timer #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Load,
  input  logic         Clear,
  input  logic [W-1:0] Load_Value,
  output logic         Expired
);

  logic [W-1:0] count_reg;

  // Count down to zero and rest there; Clear parks the counter at zero.
  always_ff @(posedge Clk) begin
    if (Reset || Clear) begin
      count_reg <= '0;
    end else if (Load) begin
      count_reg <= Load_Value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  // The last counted cycle is the one where the counter holds 1.
  assign Expired = (count_reg == W'(1));

endmodule

// File: rtl/pin_check_controller.sv
// PIN entry sequencer: waits for the stored PIN, captures an entry on each
// Enter rising edge, and opens, flags a wrong entry, or locks out.
// Optional macro PIN_CHECK_LOCKOUT_TIMER_EN: when defined, LOCKOUT ends
// after LOCKOUT_CYCLES and attempts reload; otherwise LOCKOUT is terminal.
module pin_check_controller
  import pin_check_pkg::*;
#(
  parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
  parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES,
  parameter int FAIL_CYCLES    = DEF_FAIL_CYCLES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  localparam int AW = $clog2(MAX_ATTEMPTS + 1)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Config_Done,
  input  logic [PIN_A_W-1:0] A_Pin,
  input  logic [PIN_B_W-1:0] B_Pin,
  input  logic               Enter,
  input  logic [PIN_A_W-1:0] Switches_A_Pin,
  input  logic [PIN_B_W-1:0] Switches_B_Pin,
  input  logic               Relock,
  output logic               Unlocked,
  output logic               Error,
  output logic               Locked_Out,
  output logic [AW-1:0]      Attempts_Left,
  output logic [2:0]         State
);

`ifdef PIN_CHECK_LOCKOUT_TIMER_EN
  localparam int MAX_WIN = max2(max2(OPEN_CYCLES, FAIL_CYCLES), LOCKOUT_CYCLES);
`else
  localparam int MAX_WIN = max2(OPEN_CYCLES, FAIL_CYCLES);
`endif
  localparam int TW = $clog2(MAX_WIN + 1);
  localparam logic [AW-1:0] ATTEMPTS_FULL = AW'(MAX_ATTEMPTS);

  pin_state_e         state_reg, state_next;
  logic [AW-1:0]      attempts_reg, attempts_next;
  logic [PIN_A_W-1:0] entry_a_reg;
  logic [PIN_B_W-1:0] entry_b_reg;
  logic               enter_old_reg;
  logic               enter_rising;
  logic               capture;
  logic               timer_load;
  logic               timer_clear;
  logic [TW-1:0]      timer_value;
  logic               timer_expired;

  assign enter_rising = Enter && !enter_old_reg;

  pin_cycle_timer #(.W(TW)) u_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .Load       (timer_load),
    .Clear      (timer_clear),
    .Load_Value (timer_value),
    .Expired    (timer_expired)
  );

  // State, attempt counter, entry capture and Enter edge history.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= ST_WAIT_CFG;
      attempts_reg  <= ATTEMPTS_FULL;
      entry_a_reg   <= '0;
      entry_b_reg   <= '0;
      enter_old_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      attempts_reg  <= attempts_next;
      enter_old_reg <= Enter;
      if (capture) begin
        entry_a_reg <= Switches_A_Pin;
        entry_b_reg <= Switches_B_Pin;
      end
    end
  end

  // Next-state, attempt bookkeeping and timer control.
  always_comb begin
    state_next    = state_reg;
    attempts_next = attempts_reg;
    capture       = 1'b0;
    timer_load    = 1'b0;
    timer_value   = '0;
    if (!Config_Done) begin
      // Losing the stored PIN overrides everything else.
      state_next    = ST_WAIT_CFG;
      attempts_next = ATTEMPTS_FULL;
    end else begin
      case (state_reg)
        ST_WAIT_CFG: state_next = ST_IDLE;
        ST_IDLE: begin
          if (enter_rising) begin
            capture    = 1'b1;
            state_next = ST_CHECK;
          end
        end
        ST_CHECK: begin
          timer_load = 1'b1;
          if ({entry_a_reg, entry_b_reg} == {A_Pin, B_Pin}) begin
            attempts_next = ATTEMPTS_FULL;
            state_next    = ST_OPEN;
            timer_value   = TW'(OPEN_CYCLES);
          end else if (attempts_reg > AW'(1)) begin
            attempts_next = attempts_reg - 1'b1;
            state_next    = ST_FAIL;
            timer_value   = TW'(FAIL_CYCLES);
          end else begin
            // Last allowed attempt used (saturate at zero).
            attempts_next = '0;
            state_next    = ST_LOCKOUT;
`ifdef PIN_CHECK_LOCKOUT_TIMER_EN
            timer_value   = TW'(LOCKOUT_CYCLES);
`endif
          end
        end
        ST_OPEN: begin
          if (timer_expired || Relock) state_next = ST_IDLE;
        end
        ST_FAIL: begin
          if (timer_expired) state_next = ST_IDLE;
        end
        ST_LOCKOUT: begin
`ifdef PIN_CHECK_LOCKOUT_TIMER_EN
          if (timer_expired) begin
            state_next    = ST_IDLE;
            attempts_next = ATTEMPTS_FULL;
          end
`endif
        end
        default: state_next = ST_WAIT_CFG;
      endcase
    end
    // Park the timer whenever the next state is not a timed one, so an
    // early exit (Relock, Config_Done drop) leaves no stale count behind.
    timer_clear = !timer_load &&
                  !(state_next inside {ST_OPEN, ST_FAIL, ST_LOCKOUT});
  end

  assign Unlocked      = (state_reg == ST_OPEN);
  assign Error         = (state_reg == ST_FAIL);
  assign Locked_Out    = (state_reg == ST_LOCKOUT);
  assign Attempts_Left = attempts_reg;
  assign State         = state_reg;

endmodule

// File: tb/tb_pin_check_controller.sv
// Directed bench for pin_check_controller with short windows
// (OPEN=8, FAIL=4, LOCKOUT=16, MAX_ATTEMPTS=3). Works with or without
// PIN_CHECK_LOCKOUT_TIMER_EN defined.
module tb_pin_check_controller;

  logic       Clk;
  logic       Reset;
  logic       Config_Done;
  logic [3:0] A_Pin;
  logic [2:0] B_Pin;
  logic       Enter;
  logic [3:0] Switches_A_Pin;
  logic [2:0] Switches_B_Pin;
  logic       Relock;
  logic       Unlocked;
  logic       Error;
  logic       Locked_Out;
  logic [1:0] Attempts_Left;
  logic [2:0] State;

  int n_tests = 0;
  int n_fail  = 0;

  pin_check_controller #(
    .MAX_ATTEMPTS   (3),
    .OPEN_CYCLES    (8),
    .FAIL_CYCLES    (4),
    .LOCKOUT_CYCLES (16)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Config_Done    (Config_Done),
    .A_Pin          (A_Pin),
    .B_Pin          (B_Pin),
    .Enter          (Enter),
    .Switches_A_Pin (Switches_A_Pin),
    .Switches_B_Pin (Switches_B_Pin),
    .Relock         (Relock),
    .Unlocked       (Unlocked),
    .Error          (Error),
    .Locked_Out     (Locked_Out),
    .Attempts_Left  (Attempts_Left),
    .State          (State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge Clk);
  endtask

  // One entry: Enter rises for one edge, leaving the DUT in CHECK.
  task automatic enter_pin(input logic [3:0] a, input logic [2:0] b);
    Switches_A_Pin = a;
    Switches_B_Pin = b;
    Enter = 1'b1;
    tick();
    Enter = 1'b0;
    $display("[TB] entry %h/%h -> state %0d attempts %0d", a, b, State, Attempts_Left);
  endtask

  task automatic test_reset();
    Reset = 1'b1; Config_Done = 1'b0; Enter = 1'b0; Relock = 1'b0;
    A_Pin = 4'hA; B_Pin = 3'h5; Switches_A_Pin = 4'h0; Switches_B_Pin = 3'h0;
    repeat (3) tick();
    n_tests++;
    if (State !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", State); end
    n_tests++;
    if (Attempts_Left !== 2'd3) begin n_fail++; $display("FAIL reset_attempts: got %0d want 3", Attempts_Left); end
    n_tests++;
    if ({Unlocked, Error, Locked_Out} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {Unlocked, Error, Locked_Out});
    end
    Reset = 1'b0;
  endtask

  task automatic test_wait_cfg();
    Switches_A_Pin = 4'hA; Switches_B_Pin = 3'h5;
    Enter = 1'b1; tick(); Enter = 1'b0; repeat (2) tick();
    n_tests++;
    if (State !== 3'd0) begin n_fail++; $display("FAIL wait_cfg_state: got %0d want 0", State); end
    n_tests++;
    if ({Unlocked, Error, Locked_Out} !== 3'b000) begin
      n_fail++; $display("FAIL wait_cfg_flags: got %b want 000", {Unlocked, Error, Locked_Out});
    end
    Config_Done = 1'b1;
    tick();
    n_tests++;
    if (State !== 3'd1) begin n_fail++; $display("FAIL cfg_to_idle: got %0d want 1", State); end
  endtask

  task automatic test_open();
    enter_pin(4'hA, 3'h5);
    n_tests++;
    if (State !== 3'd2) begin n_fail++; $display("FAIL open_check_state: got %0d want 2", State); end
    tick();
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (Unlocked !== 1'b1) begin n_fail++; $display("FAIL open_window[%0d]: Unlocked=%b want 1", i, Unlocked); end
      tick();
    end
    n_tests++;
    if (State !== 3'd1) begin n_fail++; $display("FAIL open_end_state: got %0d want 1", State); end
    n_tests++;
    if (Attempts_Left !== 2'd3) begin n_fail++; $display("FAIL open_end_attempts: got %0d want 3", Attempts_Left); end
  endtask

  task automatic test_wrong_entries();
    for (int k = 0; k < 3; k++) begin
      enter_pin(4'hA, 3'h4);
      tick();
      if (k < 2) begin
        n_tests++;
        if (Attempts_Left !== 2'(2 - k)) begin
          n_fail++; $display("FAIL wrong%0d_attempts: got %0d want %0d", k, Attempts_Left, 2 - k);
        end
        for (int i = 0; i < 4; i++) begin
          n_tests++;
          if (Error !== 1'b1) begin n_fail++; $display("FAIL wrong%0d_err[%0d]: Error=%b want 1", k, i, Error); end
          tick();
        end
        n_tests++;
        if (State !== 3'd1) begin n_fail++; $display("FAIL wrong%0d_idle: got %0d want 1", k, State); end
      end else begin
        n_tests++;
        if (Locked_Out !== 1'b1) begin n_fail++; $display("FAIL lockout_flag: got %b want 1", Locked_Out); end
        n_tests++;
        if (Attempts_Left !== 2'd0) begin n_fail++; $display("FAIL lockout_attempts: got %0d want 0", Attempts_Left); end
      end
    end
`ifdef PIN_CHECK_LOCKOUT_TIMER_EN
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (Locked_Out !== 1'b1) begin n_fail++; $display("FAIL lockout_window[%0d]: got %b want 1", i, Locked_Out); end
      tick();
    end
    n_tests++;
    if (State !== 3'd1) begin n_fail++; $display("FAIL lockout_end_state: got %0d want 1", State); end
    n_tests++;
    if (Attempts_Left !== 2'd3) begin n_fail++; $display("FAIL lockout_end_attempts: got %0d want 3", Attempts_Left); end
`else
    Enter = 1'b1; tick(); Enter = 1'b0;
    repeat (100) tick();
    n_tests++;
    if (State !== 3'd5) begin n_fail++; $display("FAIL lockout_persist: got %0d want 5", State); end
    n_tests++;
    if (Attempts_Left !== 2'd0) begin n_fail++; $display("FAIL lockout_persist_attempts: got %0d want 0", Attempts_Left); end
`endif
  endtask

  task automatic test_lockout_reset();
`ifdef PIN_CHECK_LOCKOUT_TIMER_EN
    for (int k = 0; k < 3; k++) begin
      enter_pin(4'hA, 3'h4);
      tick();
      if (k < 2) repeat (4) tick();
    end
    n_tests++;
    if (Locked_Out !== 1'b1) begin n_fail++; $display("FAIL relock_out_flag: got %b want 1", Locked_Out); end
`endif
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_tests++;
    if (State !== 3'd0) begin n_fail++; $display("FAIL lockout_reset_state: got %0d want 0", State); end
    n_tests++;
    if (Attempts_Left !== 2'd3) begin n_fail++; $display("FAIL lockout_reset_attempts: got %0d want 3", Attempts_Left); end
    tick();
    n_tests++;
    if (State !== 3'd1) begin n_fail++; $display("FAIL lockout_reset_idle: got %0d want 1", State); end
  endtask

  task automatic test_reload_after_wrong();
    enter_pin(4'hA, 3'h4);
    tick();
    repeat (4) tick();
    n_tests++;
    if (Attempts_Left !== 2'd2) begin n_fail++; $display("FAIL reload_pre: got %0d want 2", Attempts_Left); end
    enter_pin(4'hA, 3'h5);
    tick();
    n_tests++;
    if (Unlocked !== 1'b1) begin n_fail++; $display("FAIL reload_open: got %b want 1", Unlocked); end
    n_tests++;
    if (Attempts_Left !== 2'd3) begin n_fail++; $display("FAIL reload_attempts: got %0d want 3", Attempts_Left); end
    Relock = 1'b1; tick(); Relock = 1'b0;
  endtask

  task automatic test_relock();
    Switches_A_Pin = 4'hA; Switches_B_Pin = 3'h5;
    Enter = 1'b1;
    tick();
    tick();
    n_tests++;
    if (Unlocked !== 1'b1) begin n_fail++; $display("FAIL relock_open: got %b want 1", Unlocked); end
    repeat (2) tick();
    Relock = 1'b1;
    tick();
    Relock = 1'b0;
    n_tests++;
    if (State !== 3'd1) begin n_fail++; $display("FAIL relock_idle: got %0d want 1", State); end
    repeat (3) tick();
    n_tests++;
    if (State !== 3'd1) begin n_fail++; $display("FAIL relock_held_enter: got %0d want 1", State); end
    Enter = 1'b0;
    tick();
  endtask

  task automatic test_relock_at_expiry();
    enter_pin(4'hA, 3'h5);
    tick();
    repeat (7) tick();
    n_tests++;
    if (Unlocked !== 1'b1) begin n_fail++; $display("FAIL expiry_last_open: got %b want 1", Unlocked); end
    Relock = 1'b1;
    tick();
    Relock = 1'b0;
    n_tests++;
    if (State !== 3'd1) begin n_fail++; $display("FAIL expiry_relock_idle: got %0d want 1", State); end
  endtask

  task automatic test_switch_change();
    enter_pin(4'hA, 3'h5);
    Switches_A_Pin = 4'h3;
    Switches_B_Pin = 3'h0;
    tick();
    n_tests++;
    if (Unlocked !== 1'b1) begin n_fail++; $display("FAIL switch_change_verdict: got %b want 1", Unlocked); end
    Relock = 1'b1; tick(); Relock = 1'b0;
  endtask

  task automatic test_config_drop();
    enter_pin(4'hA, 3'h5);
    tick();
    repeat (2) tick();
    Config_Done = 1'b0;
    tick();
    n_tests++;
    if (State !== 3'd0) begin n_fail++; $display("FAIL drop_open_state: got %0d want 0", State); end
    n_tests++;
    if (Unlocked !== 1'b0) begin n_fail++; $display("FAIL drop_open_unlocked: got %b want 0", Unlocked); end
    Config_Done = 1'b1;
    tick();
    enter_pin(4'hA, 3'h4);
    tick();
    n_tests++;
    if (Attempts_Left !== 2'd2) begin n_fail++; $display("FAIL drop_fail_pre: got %0d want 2", Attempts_Left); end
    Config_Done = 1'b0;
    tick();
    n_tests++;
    if (State !== 3'd0) begin n_fail++; $display("FAIL drop_fail_state: got %0d want 0", State); end
    n_tests++;
    if (Attempts_Left !== 2'd3) begin n_fail++; $display("FAIL drop_fail_attempts: got %0d want 3", Attempts_Left); end
    Config_Done = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_wait_cfg();
    test_open();
    test_wrong_entries();
    test_lockout_reset();
    test_reload_after_wrong();
    test_relock();
    test_relock_at_expiry();
    test_switch_change();
    test_config_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d tests", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
